// File: rtl/apb_regfile_slave.sv
// APB slave fronting a DEPTH x D_WIDTH register file.
// Supports wait states, byte-lane write strobes, out-of-range error responses and aborted transfers.
module apb_regfile_slave #(
    parameter int                 A_WIDTH     = 8,
    parameter int                 D_WIDTH     = 32,
    parameter int                 DEPTH       = 16,
    parameter int                 WAIT_STATES = 0,
    parameter logic [D_WIDTH-1:0] RESET_VAL   = 'h12
) (
    input  logic                 p_clk,
    input  logic                 p_rstn,
    input  logic                 p_sel,
    input  logic                 p_enable,
    input  logic                 p_write,
    input  logic [A_WIDTH-1:0]   p_addr,
    input  logic [D_WIDTH-1:0]   p_wdata,
    input  logic [D_WIDTH/8-1:0] p_strb,
    output logic [D_WIDTH-1:0]   p_rdata,
    output logic                 p_ready,
    output logic                 p_slverr
);

    localparam int N_LANES = D_WIDTH / 8;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                 state_q, state_d, phase;
    logic [A_WIDTH-1:0]     addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [D_WIDTH-1:0]     wdata_q, wdata_d;
    logic [N_LANES-1:0]     strb_q, strb_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [D_WIDTH-1:0]     mem_q [DEPTH];
    logic [D_WIDTH-1:0]     mem_d [DEPTH];

    logic                   addr_ok;
    logic [IDX_W-1:0]       idx;
    logic                   ready;

    // state_q holds the phase we expect the bus to be in. The live phase also
    // looks at p_sel/p_enable, so a setup cycle is recognised in the cycle it
    // appears and a dropped select aborts without ever raising p_ready.
    always_comb begin
        phase = IDLE;
        if (state_q == ACCESS) begin
            if (p_sel && p_enable) phase = ACCESS;
        end else if (p_sel && !p_enable) begin
            phase = SETUP;
        end
    end

    assign addr_ok = {1'b0, addr_q} < (A_WIDTH+1)'(DEPTH);
    assign idx     = addr_q[IDX_W-1:0];
    assign ready   = (phase == ACCESS) && (cnt_q == 4'(WAIT_STATES));

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = IDLE;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (phase)
            SETUP: begin
                addr_d  = p_addr;
                wr_d    = p_write;
                wdata_d = p_wdata;
                strb_d  = p_strb;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!ready) begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ACCESS;
                end else if (wr_q && addr_ok) begin
                    for (int i = 0; i < N_LANES; i++) begin
                        if (strb_q[i]) mem_d[idx][8*i +: 8] = wdata_q[8*i +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        p_ready  = ready;
        p_slverr = ready && !addr_ok;
        p_rdata  = (ready && !wr_q && addr_ok) ? mem_q[idx] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d input regardless of statement order.
    // NOTE: the register file is built from resettable flops rather than a RAM,
    // because every word must read RESET_VAL straight after reset.
    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave.
// Two instances (WAIT_STATES 0 and 3) share one APB bus; a queue scoreboard checks every response.
module tb_apb_regfile_slave;

    logic        p_clk = 1'b0;
    logic        p_rstn = 1'b0;
    logic        p_sel = 1'b0;
    logic        p_enable = 1'b0;
    logic        p_write = 1'b0;
    logic [7:0]  p_addr = '0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_strb = '0;

    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3;

    always #5 p_clk = ~p_clk;

    apb_regfile_slave #(.A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .WAIT_STATES(0), .RESET_VAL('h12)) dut0 (
        .p_clk(p_clk), .p_rstn(p_rstn), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_strb(p_strb),
        .p_rdata(rdata0), .p_ready(ready0), .p_slverr(err0)
    );

    apb_regfile_slave #(.A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .WAIT_STATES(3), .RESET_VAL('h12)) dut3 (
        .p_clk(p_clk), .p_rstn(p_rstn), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_strb(p_strb),
        .p_rdata(rdata3), .p_ready(ready3), .p_slverr(err3)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic mon_ready(input int which);
        return (which == 3) ? ready3 : ready0;
    endfunction

    function automatic logic mon_err(input int which);
        return (which == 3) ? err3 : err0;
    endfunction

    function automatic logic [31:0] mon_rdata(input int which);
        return (which == 3) ? rdata3 : rdata0;
    endfunction

    // Expected contents of dut0 after the directed table has run.
    function automatic logic [31:0] exp_word(input int a);
        case (a)
            3:       return 32'hDEADBEEF;
            5:       return 32'hDEADBEAA;
            7:       return 32'hA500A512;
            15:      return 32'hCAFEF00D;
            default: return 32'h00000012;
        endcase
    endfunction

    // Entered and left at posedge+1; the bus is left in access phase so a
    // following call starts its setup cycle with no idle cycle in between.
    // During access the address/data/write/strobe lines are scrambled: the
    // DUT must use the values latched in setup.
    task automatic xfer(input vec_t v, input int which, input int ws);
        exp_t e;
        int   waits;
        bit   done;
        p_sel = 1'b1; p_enable = 1'b0; p_write = v.wr;
        p_addr = v.addr; p_wdata = v.wdata; p_strb = v.strb;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.waits = ws;
        sb.push_back(e);
        @(negedge p_clk);
        check("setup_ready", 32'(mon_ready(which)), 32'd0);
        @(posedge p_clk); #1;
        p_enable = 1'b1; p_write = ~v.wr; p_addr = ~v.addr; p_wdata = ~v.wdata; p_strb = ~v.strb;
        waits = 0;
        done  = 1'b0;
        while (!done && waits <= 20) begin
            @(negedge p_clk);
            if (mon_ready(which)) begin
                done = 1'b1;
            end else begin
                check("wait_slverr", 32'(mon_err(which)), 32'd0);
                waits++;
                @(posedge p_clk); #1;
            end
        end
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty: got response with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (!done) begin
                n_vec++; n_err++;
                $display("FAIL ready_timeout: got no p_ready after %0d cycles, expected %0d waits", waits, e.waits);
            end else begin
                check("rdata",   mon_rdata(which),  e.rdata);
                check("slverr",  32'(mon_err(which)), 32'(e.err));
                check("latency", 32'(waits),        32'(e.waits));
            end
        end
        @(posedge p_clk); #1;
    endtask

    task automatic idle();
        p_sel = 1'b0; p_enable = 1'b0;
        @(posedge p_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge p_clk);
        @(negedge p_clk);
        check("rst_ready0", 32'(ready0), 32'd0);
        check("rst_err0",   32'(err0),   32'd0);
        check("rst_rdata0", rdata0,      32'd0);
        check("rst_ready3", 32'(ready3), 32'd0);
        check("rst_err3",   32'(err3),   32'd0);
        check("rst_rdata3", rdata3,      32'd0);
        p_rstn = 1'b1;
        @(posedge p_clk); #1;

        // Reset values read back, back-to-back, 2-cycle transfers
        for (int a = 0; a < 16; a++) xfer(mk(1'b0, 8'(a), 32'h0, 4'h0, 32'h12, 1'b0), 0, 0);

        // Directed table, back-to-back on the zero-wait instance
        tbl.push_back(mk(1'b1, 8'd3,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 8'd3,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 8'd5,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 8'd5,  32'h000000AA, 4'b0001, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 8'd5,  32'h0,        4'b1111, 32'hDEADBEAA, 1'b0));
        tbl.push_back(mk(1'b1, 8'd6,  32'h12345678, 4'b0000, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 8'd6,  32'h0,        4'b0000, 32'h00000012, 1'b0));
        tbl.push_back(mk(1'b1, 8'd7,  32'hA5A5A5A5, 4'b1010, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 8'd7,  32'h0,        4'b0000, 32'hA500A512, 1'b0));
        tbl.push_back(mk(1'b1, 8'd20, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 8'd20, 32'h0,        4'b0000, 32'h0,        1'b1));
        tbl.push_back(mk(1'b1, 8'd16, 32'h11111111, 4'b1111, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 8'd16, 32'h0,        4'b0000, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 8'd15, 32'h0,        4'b0000, 32'h00000012, 1'b0));
        tbl.push_back(mk(1'b1, 8'd15, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 8'd15, 32'h0,        4'b0000, 32'hCAFEF00D, 1'b0));
        foreach (tbl[i]) xfer(tbl[i], 0, 0);
        idle();

        // Error writes must have left every word alone
        for (int a = 0; a < 16; a++) xfer(mk(1'b0, 8'(a), 32'h0, 4'h0, exp_word(a), 1'b0), 0, 0);
        idle();

        // Three wait states
        xfer(mk(1'b1, 8'd9, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0), 3, 3);
        idle();
        xfer(mk(1'b0, 8'd9, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0), 3, 3);
        idle();

        // Abort: p_sel dropped in the second wait cycle
        p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1;
        p_addr = 8'd9; p_wdata = 32'h11223344; p_strb = 4'b1111;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        @(negedge p_clk);
        check("abort_wait1_ready", 32'(ready3), 32'd0);
        @(posedge p_clk); #1;
        p_sel = 1'b0; p_enable = 1'b0;
        @(negedge p_clk);
        check("abort_drop_ready", 32'(ready3), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge p_clk); #1;
            @(negedge p_clk);
            check("abort_idle_ready", 32'(ready3), 32'd0);
            check("abort_idle_err",   32'(err3),   32'd0);
        end
        @(posedge p_clk); #1;
        xfer(mk(1'b0, 8'd9, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0), 3, 3);
        idle();

        // Asynchronous reset in the completion cycle of a wait-state write
        p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1;
        p_addr = 8'd7; p_wdata = 32'h55555555; p_strb = 4'b1111;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        repeat (3) @(posedge p_clk);
        @(negedge p_clk);
        check("pre_reset_ready", 32'(ready3), 32'd1);
        #2;
        p_rstn = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready3), 32'd0);
        check("async_rst_err",   32'(err3),   32'd0);
        check("async_rst_rdata", rdata3,      32'd0);
        p_sel = 1'b0; p_enable = 1'b0;
        @(negedge p_clk);
        p_rstn = 1'b1;
        @(posedge p_clk); #1;
        for (int a = 0; a < 16; a++) xfer(mk(1'b0, 8'(a), 32'h0, 4'h0, 32'h12, 1'b0), 3, 3);
        idle();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
